// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in, parallel-out frame receiver.
package sipo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int MAX_WIDTH = 32;

    // Bit counter must hold WIDTH-1 without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial input and valid/ready parallel output bundle of the frame receiver.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
) ();

    logic             sin;
    logic             sof;
    logic             pready;
    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             busy;
    logic             overrun;

    modport master (
        output sin, sof, pready,
        input  pout, pvalid, busy, overrun
    );

    modport slave (
        input  sin, sof, pready,
        output pout, pvalid, busy, overrun
    );

endinterface

// File: rtl/sipo_bit_counter.sv
// Load/increment/clear bit counter with a terminal flag at WIDTH-1.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic term_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over load, load over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (load_i) begin
            cnt_d = CW'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_frame_rx.sv
// Rebuilds MSB-first serial frames into WIDTH-bit words on a one-entry
// valid/ready output with sticky overrun.
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sipo_frame_rx_if.slave       rx
);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_SHIFT = SHIFT;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvalid_q, pvalid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] first_s;
    logic             complete_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             cnt_clr_s;
    logic             cnt_term_s;

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load_s),
        .inc_i  (cnt_inc_s),
        .clr_i  (cnt_clr_s),
        .term_o (cnt_term_s)
    );

    assign word_s  = {shreg_q[WIDTH-2:0], rx.sin};
    assign first_s = {{(WIDTH-1){1'b0}}, rx.sin};

    // Frame FSM: sof always (re)starts a frame, even on the completion edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        cnt_clr_s  = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx.sof) begin
                    shreg_d    = first_s;
                    cnt_load_s = 1'b1;
                    state_d    = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (rx.sof) begin
                    shreg_d    = first_s;
                    cnt_load_s = 1'b1;
                    state_d    = S_SHIFT;
                end else if (cnt_term_s) begin
                    shreg_d    = word_s;
                    cnt_clr_s  = 1'b1;
                    complete_s = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    shreg_d   = word_s;
                    cnt_inc_s = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Output slot: accept a new word if empty or drained on this same edge.
    always_comb begin
        pout_d    = pout_q;
        pvalid_d  = pvalid_q;
        overrun_d = overrun_q;
        if (complete_s) begin
            if (!pvalid_q || rx.pready) begin
                pout_d   = word_s;
                pvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pvalid_q && rx.pready) begin
            pvalid_d = 1'b0;
        end else begin
            pvalid_d = pvalid_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            pout_q    <= {WIDTH{1'b0}};
            pvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pout_q    <= pout_d;
            pvalid_q  <= pvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx.pout    = pout_q;
    assign rx.pvalid  = pvalid_q;
    assign rx.busy    = (state_q == S_SHIFT);
    assign rx.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx at WIDTH=4 with hand-computed expectations.
module tb_sipo_frame_rx;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    sipo_frame_rx_if #(.WIDTH(4)) bus ();

    sipo_frame_rx #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with given sof/sin; inputs change 1 time unit after the edge.
    task automatic drive_bit(input logic s, input logic b);
        bus.sof = s;
        bus.sin = b;
        @(posedge clk);
        #1;
        bus.sof = 1'b0;
        bus.sin = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            drive_bit(i == 0, w[3-i]);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.sin      = 1'b0;
        bus.sof      = 1'b0;
        bus.pready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pout", 32'(bus.pout), 32'h0);
        check_eq("rst_pvalid", 32'(bus.pvalid), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'h0);
        reset = 1'b0;

        // Basic frame 1010
        bus.pready = 1'b1;
        drive_bit(1'b1, 1'b1);
        check_eq("basic_busy_after_sof", 32'(bus.busy), 32'h1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        check_eq("basic_pvalid_early", 32'(bus.pvalid), 32'h0);
        drive_bit(1'b0, 1'b0);
        check_eq("basic_pout", 32'(bus.pout), 32'hA);
        check_eq("basic_pvalid", 32'(bus.pvalid), 32'h1);
        check_eq("basic_busy_done", 32'(bus.busy), 32'h0);
        drive_bit(1'b0, 1'b0);
        check_eq("basic_pvalid_drained", 32'(bus.pvalid), 32'h0);

        // Back-to-back 1010, 0110
        send_frame(4'b1010);
        check_eq("b2b_pout1", 32'(bus.pout), 32'hA);
        drive_bit(1'b1, 1'b0);
        check_eq("b2b_busy_restart", 32'(bus.busy), 32'h1);
        check_eq("b2b_pvalid_consumed", 32'(bus.pvalid), 32'h0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        check_eq("b2b_pout2", 32'(bus.pout), 32'h6);
        check_eq("b2b_pvalid2", 32'(bus.pvalid), 32'h1);
        check_eq("b2b_overrun", 32'(bus.overrun), 32'h0);
        drive_bit(1'b0, 1'b0);

        // Backpressure and overrun
        bus.pready = 1'b0;
        send_frame(4'b1100);
        check_eq("bp_pout1", 32'(bus.pout), 32'hC);
        check_eq("bp_overrun_none", 32'(bus.overrun), 32'h0);
        send_frame(4'b0011);
        check_eq("bp_pout_held", 32'(bus.pout), 32'hC);
        check_eq("bp_pvalid_held", 32'(bus.pvalid), 32'h1);
        check_eq("bp_overrun", 32'(bus.overrun), 32'h1);
        bus.pready = 1'b1;
        drive_bit(1'b0, 1'b0);
        check_eq("bp_pvalid_drained", 32'(bus.pvalid), 32'h0);
        check_eq("bp_overrun_sticky", 32'(bus.overrun), 32'h1);
        pulse_reset();
        check_eq("bp_overrun_reset", 32'(bus.overrun), 32'h0);

        // Consume and complete on the same edge
        bus.pready = 1'b0;
        send_frame(4'b0101);
        check_eq("sim_hold5", 32'(bus.pout), 32'h5);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        check_eq("sim_still5", 32'(bus.pout), 32'h5);
        bus.pready = 1'b1;
        drive_bit(1'b0, 1'b1);
        check_eq("sim_pout9", 32'(bus.pout), 32'h9);
        check_eq("sim_pvalid", 32'(bus.pvalid), 32'h1);
        check_eq("sim_overrun", 32'(bus.overrun), 32'h0);
        drive_bit(1'b0, 1'b0);
        check_eq("sim_drained", 32'(bus.pvalid), 32'h0);

        // sof restart mid-frame
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b0);
        check_eq("rs_busy", 32'(bus.busy), 32'h1);
        drive_bit(1'b0, 1'b1);
        check_eq("rs_pvalid_a", 32'(bus.pvalid), 32'h0);
        drive_bit(1'b0, 1'b1);
        check_eq("rs_pvalid_b", 32'(bus.pvalid), 32'h0);
        drive_bit(1'b0, 1'b1);
        check_eq("rs_pout", 32'(bus.pout), 32'h7);
        check_eq("rs_pvalid", 32'(bus.pvalid), 32'h1);
        check_eq("rs_overrun", 32'(bus.overrun), 32'h0);

        // Reset mid-frame while a word is still held
        bus.pready = 1'b0;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        pulse_reset();
        check_eq("mr_pout", 32'(bus.pout), 32'h0);
        check_eq("mr_pvalid", 32'(bus.pvalid), 32'h0);
        check_eq("mr_busy", 32'(bus.busy), 32'h0);
        check_eq("mr_overrun", 32'(bus.overrun), 32'h0);
        bus.pready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b0, 1'b1);
            check_eq("mr_no_sof_pvalid", 32'(bus.pvalid), 32'h0);
            check_eq("mr_no_sof_busy", 32'(bus.busy), 32'h0);
        end
        send_frame(4'b1111);
        check_eq("mr_poutF", 32'(bus.pout), 32'hF);
        check_eq("mr_pvalidF", 32'(bus.pvalid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-in, parallel-out frame receiver. It sits directly downstream of the team's 4-bit parallel-in/serial-out shift register and reconstructs WIDTH-bit words from its MSB-first serial stream. A start-of-frame strobe from the transmit side marks the first bit of each frame. Completed words are presented on a one-entry valid/ready output with sticky overrun detection.

## Interface
- WIDTH, default 4: bits per frame; legal range 2..32.
- clk  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high; sampled on rising edge of clk.
- sin  in  1: serial data, MSB first; sampled every clk edge.
- sof  in  1: start-of-frame; high in the cycle whose sin is the frame MSB.
- pout  out  WIDTH: received word; stable while pvalid=1.
- pvalid  out  1: pout holds an unconsumed word.
- pready  in  1: consumer accepts; transfer on edge with pvalid&&pready.
- busy  out  1: frame capture in progress (state SHIFT).
- overrun  out  1: sticky; a completed word was dropped because the output was full.

## Operation
- States: IDLE, SHIFT.
- IDLE: sin ignored unless sof=1. On sof: shreg <= {.., sin} (first bit), bitcnt <= 1, go to SHIFT.
- SHIFT: each edge shreg <= {shreg[WIDTH-2:0], sin}, bitcnt++.
- Completion: the edge where bitcnt==WIDTH-1 samples the last bit. The word {shreg[WIDTH-2:0], sin} goes straight to the output register, and the state returns to IDLE.
- sof=1 while in SHIFT: the partial frame is discarded silently. The current sin becomes bit 1 of a new frame (bitcnt <= 1), and the state stays SHIFT. No overrun is flagged.
- sof on the completion edge is illegal for WIDTH≥2 and is treated as a restart (the partial word is discarded).
- Output register: loaded at completion when it is empty or being consumed on the same edge (pvalid&&pready). Otherwise the new word is dropped, pout/pvalid are unchanged, and overrun <= 1.
- pvalid clears on an edge with pvalid&&pready and no simultaneous completion.
- overrun is cleared only by reset.
- Arithmetic: bitcnt width is $clog2(WIDTH)+1. It never wraps: completion resets it to 0.

## Timing
- Reset values: pout=0, pvalid=0, busy=0, overrun=0, state=IDLE, bitcnt=0, shreg=0.
- Reset mid-frame: the partial frame is lost and the held output word is lost. The next frame needs a fresh sof.
- Latency: with the first bit sampled at edge k, pvalid is high after edge k+WIDTH-1, and pout is valid in the same cycle.
- Back-to-back frames: sof is legal in the cycle immediately after the completion edge, with zero idle cycles. Sustained throughput is 1 word per WIDTH cycles when pready=1.
- Upstream pairing: the transmitter asserts sof in the cycle after its load edge, i.e. the first cycle its serial output shows the MSB.
- busy is high from the edge after sof through the completion edge, then low. All outputs are registered.

## Structure
- Shared package sipo_pkg:
  - state enum rx_state_t {IDLE, SHIFT};
  - localparam MAX_WIDTH=32.
- One natural sub-module: sipo_bit_counter. It is a load/increment/clear counter with a terminal flag (cnt==WIDTH-1), instantiated once.
- Shift register, FSM and output register stay in the top module.

## Test plan
- Basic, WIDTH=4, pready=1:
  - Stimulus: sof with sin=1 at edge 1, then sin=0,1,0 at edges 2-4.
  - Required: pout=4'hA and pvalid=1 after edge 4; pvalid=0 after edge 5.
- Back-to-back:
  - Stimulus: frames 1010 then 0110 with sof on consecutive frame boundaries, no gap.
  - Required: pout=4'hA after edge 4 and 4'h6 after edge 8; overrun=0.
- Backpressure/overrun:
  - Stimulus: pready=0, send 1100 then 0011.
  - Required: pout stays 4'hC, overrun=1 after edge 8. Then pready=1 for one edge gives pvalid=0, and overrun stays 1.
- Simultaneous consume and complete:
  - Stimulus: hold 4'h5 with pready=0, send 1001, and raise pready on its completion edge.
  - Required: pout=4'h9, pvalid=1, overrun=0.
- sof restart:
  - Stimulus: sof, bits 1,1, then sof with bits 0,1,1,1.
  - Required: only pout=4'h7 is produced; overrun=0.
- Reset mid-frame:
  - Stimulus: assert reset after 2 bits of a frame; afterwards keep driving bits without sof, then send a proper sof frame of 1111.
  - Required: all outputs 0 after the reset edge. No word is produced until sof; then pout=4'hF.
